// File: rtl/score_display_multi.sv
// rtl/score_display_multi.sv - multi-digit score sprite renderer with sequential BCD conversion
// Converted digits are latched at frame start so a frame never shows a half-updated score.
module score_display_multi #(
  parameter int SCORE_W    = 14,
  parameter int NUM_DIGITS = 4,
  parameter int X_POS      = 16,
  parameter int Y_POS      = 16,
  parameter int SCALE_SH   = 1,
  parameter int LZ_BLANK   = 1
) (
  input  logic               vga_clk,
  input  logic               reset,
  input  logic [SCORE_W-1:0] score_in,
  input  logic               score_valid,
  output logic               busy,
  output logic               overflow,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  input  logic               blank,
  output logic [11:0]        rom_address,
  input  logic [3:0]         rom_q,
  output logic [3:0]         pix_index,
  output logic               pix_hit
);

  localparam int BW = 4 * NUM_DIGITS;
  localparam int CW = 16 << SCALE_SH;

  function automatic logic [39:0] pow10(input int n);
    logic [39:0] r;
    r = 40'd1;
    for (int i = 0; i < n; i++) r = r * 40'd10;
    return r;
  endfunction

  localparam logic [39:0] MAX_VAL = pow10(NUM_DIGITS) - 40'd1;
  localparam logic [10:0] X_LO = 11'(X_POS);
  localparam logic [10:0] X_HI = 11'(X_POS + NUM_DIGITS * CW);
  localparam logic [10:0] Y_LO = 11'(Y_POS);
  localparam logic [10:0] Y_HI = 11'(Y_POS + CW);

  typedef enum logic [1:0] {IDLE, CLAMP, SHIFT, DONE} state_t;
  state_t state, state_next;

  logic [SCORE_W-1:0] bin;
  logic [BW-1:0]      bcd, bcd_adj, pending, shown;
  logic               ovf_pend, pending_ovf;
  logic [5:0]         cnt;
  logic               frame_start;

  assign frame_start = (DrawX == 10'd0) && (DrawY == 10'd0);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (score_valid && !busy) state_next = CLAMP;
      CLAMP:   state_next = SHIFT;
      SHIFT:   if (cnt == 6'd1) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
    end
  end

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      bin         <= '0;
      bcd         <= '0;
      cnt         <= '0;
      ovf_pend    <= 1'b0;
      pending     <= '0;
      pending_ovf <= 1'b0;
      shown       <= '0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (score_valid && !busy) bin <= score_in;
        CLAMP: begin
          if (40'(bin) > MAX_VAL) begin
            bin      <= MAX_VAL[SCORE_W-1:0];
            ovf_pend <= 1'b1;
          end else begin
            ovf_pend <= 1'b0;
          end
          bcd <= '0;
          cnt <= 6'(SCORE_W);
        end
        SHIFT: begin
          {bcd, bin} <= {bcd_adj, bin} << 1;
          cnt        <= cnt - 6'd1;
        end
        DONE: begin
          pending     <= bcd;
          pending_ovf <= ovf_pend;
        end
        default: ;
      endcase
      // Nonblocking: a DONE in the frame-start cycle is picked up next frame.
      if (frame_start) begin
        shown    <= pending;
        overflow <= pending_ovf;
      end
    end
  end

  logic [10:0] x11, y11, dx, dy;
  logic [2:0]  slot;
  logic [3:0]  row, col, digit;
  logic        in_area, blanked, zero_run;
  logic        unused_bits;

  assign x11     = {1'b0, DrawX};
  assign y11     = {1'b0, DrawY};
  assign dx      = x11 - X_LO;
  assign dy      = y11 - Y_LO;
  assign slot    = dx[4+SCALE_SH +: 3];
  assign col     = dx[SCALE_SH +: 4];
  assign row     = dy[SCALE_SH +: 4];
  assign in_area = (x11 >= X_LO) && (x11 < X_HI) && (y11 >= Y_LO) && (y11 < Y_HI);
  assign unused_bits = ^{dx, dy};

  always_comb begin
    digit    = 4'd0;
    blanked  = 1'b0;
    zero_run = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      zero_run = zero_run && (shown[4*(NUM_DIGITS-1-k) +: 4] == 4'd0);
      if (slot == 3'(k)) begin
        digit   = shown[4*(NUM_DIGITS-1-k) +: 4];
        blanked = (LZ_BLANK != 0) && (k < NUM_DIGITS - 1) && zero_run;
      end
    end
  end

  assign rom_address = in_area ? {digit, row, col} : 12'd0;

  logic s1_in_area, s1_blanked, s1_blank, hit_next;

  assign hit_next = s1_in_area && !s1_blanked && s1_blank && (rom_q != 4'd0);

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      s1_in_area <= 1'b0;
      s1_blanked <= 1'b0;
      s1_blank   <= 1'b0;
      pix_hit    <= 1'b0;
      pix_index  <= 4'd0;
    end else begin
      s1_in_area <= in_area;
      s1_blanked <= blanked;
      s1_blank   <= blank;
      pix_hit    <= hit_next;
      pix_index  <= hit_next ? rom_q : 4'd0;
    end
  end

endmodule

// File: tb/tb_score_display_multi.sv
// tb/tb_score_display_multi.sv - directed bench for score_display_multi
// Two instances differ only in leading-zero blanking; the ROM stub returns digit+1 unless forced.
module tb_score_display_multi;

  logic        vga_clk = 1'b0;
  logic        reset, score_valid, blank;
  logic [13:0] score_in;
  logic [9:0]  DrawX, DrawY;
  logic        busy, overflow, pix_hit;
  logic [11:0] rom_address;
  logic [3:0]  rom_q, pix_index;
  logic        busy_n, overflow_n, pix_hit_n;
  logic [11:0] rom_address_n;
  logic [3:0]  rom_q_n, pix_index_n;
  logic        force_en;
  logic [3:0]  force_q;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 vga_clk = ~vga_clk;

  score_display_multi dut (
    .vga_clk(vga_clk), .reset(reset), .score_in(score_in), .score_valid(score_valid),
    .busy(busy), .overflow(overflow), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .rom_address(rom_address), .rom_q(rom_q), .pix_index(pix_index), .pix_hit(pix_hit)
  );

  score_display_multi #(.LZ_BLANK(0)) dut_nz (
    .vga_clk(vga_clk), .reset(reset), .score_in(score_in), .score_valid(score_valid),
    .busy(busy_n), .overflow(overflow_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .rom_address(rom_address_n), .rom_q(rom_q_n), .pix_index(pix_index_n), .pix_hit(pix_hit_n)
  );

  always @(negedge vga_clk) begin
    rom_q   <= force_en ? force_q : rom_address[11:8] + 4'd1;
    rom_q_n <= force_en ? force_q : rom_address_n[11:8] + 4'd1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic park();
    DrawX = 10'd700;
    DrawY = 10'd600;
  endtask

  task automatic frame();
    DrawX = 10'd0;
    DrawY = 10'd0;
    tick();
    park();
  endtask

  task automatic convert(input logic [13:0] v);
    score_in    = v;
    score_valid = 1'b1;
    tick();
    score_valid = 1'b0;
    for (int i = 0; i < 60 && busy; i++) tick();
    check("conv_done", busy, 1'b0);
  endtask

  task automatic read_digits(output logic [15:0] d);
    for (int k = 0; k < 4; k++) begin
      DrawX = 10'(16 + k * 32 + 10);
      DrawY = 10'd26;
      tick();
      d[4*(3-k) +: 4] = rom_address[11:8];
    end
    park();
  endtask

  task automatic probe_addr(input string tag, input int x, input int y, input logic [11:0] exp);
    DrawX = 10'(x);
    DrawY = 10'(y);
    tick();
    check(tag, rom_address, exp);
  endtask

  task automatic pix_at(input int x, input int y);
    DrawX = 10'(x);
    DrawY = 10'(y);
    tick();
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;
    int bc, cnt_lz, cnt_nz;
    reset = 1'b1; score_valid = 1'b0; score_in = '0; blank = 1'b1;
    force_en = 1'b0; force_q = 4'd0;
    park();
    tick(); tick(); tick();
    check("rst_busy", busy, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_hit", pix_hit, 1'b0);
    check("rst_index", pix_index, 4'd0);
    reset = 1'b0;
    read_digits(d);
    check("rst_digits", d, 16'h0000);

    score_in = 14'd1234;
    score_valid = 1'b1;
    bc = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      score_valid = 1'b0;
      if (busy) bc++;
    end
    check("busy_len", bc, 16);
    read_digits(d);
    check("pre_frame", d, 16'h0000);
    frame();
    read_digits(d);
    check("digits_1234", d, 16'h1234);
    check("ovf_1234", overflow, 1'b0);

    force_en = 1'b1; force_q = 4'd5;
    tick(); tick();
    DrawX = 10'd50; DrawY = 10'd22;
    #1;
    check("addr_lat", rom_address, 12'h231);
    tick();
    check("lat_t1_hit", pix_hit, 1'b0);
    tick();
    check("lat_t2_hit", pix_hit, 1'b1);
    check("lat_t2_index", pix_index, 4'd5);
    blank = 1'b0;
    tick(); tick();
    check("blank_hit", pix_hit, 1'b0);
    check("blank_index", pix_index, 4'd0);
    blank = 1'b1;
    force_en = 1'b0;
    probe_addr("left_out", 15, 22, 12'h000);
    probe_addr("right_in", 143, 22, 12'h43F);
    probe_addr("right_out", 144, 22, 12'h000);
    probe_addr("bottom_in", 50, 47, 12'h2F1);
    probe_addr("bottom_out", 50, 48, 12'h000);
    probe_addr("top_out", 50, 15, 12'h000);
    park();

    convert(14'd5678);
    read_digits(d);
    check("tear_hold", d, 16'h1234);
    frame();
    read_digits(d);
    check("tear_update", d, 16'h5678);

    score_in = 14'd1111; score_valid = 1'b1;
    tick();
    score_valid = 1'b0;
    tick(); tick(); tick();
    score_in = 14'd2222; score_valid = 1'b1;
    tick();
    score_valid = 1'b0;
    for (int i = 0; i < 60 && busy; i++) tick();
    check("ign_done", busy, 1'b0);
    frame();
    read_digits(d);
    check("busy_ignore", d, 16'h1111);

    convert(14'd12345);
    frame();
    read_digits(d);
    check("clamp_digits", d, 16'h9999);
    check("clamp_ovf", overflow, 1'b1);
    convert(14'd5);
    check("ovf_hold", overflow, 1'b1);
    frame();
    check("ovf_clear", overflow, 1'b0);
    read_digits(d);
    check("digits_5", d, 16'h0005);

    convert(14'd7);
    frame();
    cnt_lz = 0; cnt_nz = 0;
    for (int y = 16; y < 48; y++)
      for (int x = 16; x < 112; x++) begin
        pix_at(x, y);
        if (pix_hit) cnt_lz++;
        if (pix_hit_n && pix_index_n == 4'd1) cnt_nz++;
      end
    check("lz_blank_cnt", cnt_lz, 0);
    check("nz_zero_cnt", cnt_nz, 3072);
    pix_at(122, 26);
    check("lz_slot3_hit", pix_hit, 1'b1);
    check("lz_slot3_index", pix_index, 4'd8);

    convert(14'd0);
    frame();
    pix_at(122, 26);
    check("zero_slot3_hit", pix_hit, 1'b1);
    check("zero_slot3_index", pix_index, 4'd1);
    pix_at(90, 26);
    check("zero_slot2_hit", pix_hit, 1'b0);
    park();

    convert(14'd4321);
    frame();
    read_digits(d);
    check("pre_rst_digits", d, 16'h4321);
    score_in = 14'd999; score_valid = 1'b1;
    tick();
    score_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_busy", busy, 1'b0);
    check("midrst_hit", pix_hit, 1'b0);
    check("midrst_index", pix_index, 4'd0);
    read_digits(d);
    check("midrst_digits", d, 16'h0000);
    frame();
    read_digits(d);
    check("midrst_pending", d, 16'h0000);
    convert(14'd42);
    frame();
    read_digits(d);
    check("post_rst_42", d, 16'h0042);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
